// File: rtl/infix_sequencer_if.sv
// infix_sequencer_if: infix token input handshake and postfix output strobes.
// slave is the sequencer's view; master is the token source / evaluator side.
interface infix_sequencer_if;
    logic [7:0] IN_TOKEN;
    logic       IN_IS_SIGN;
    logic       IN_STB;
    logic       IN_END;
    logic       IN_READY;
    logic [7:0] OUT_NUMBER;
    logic       OUT_NUMBER_STB;
    logic [7:0] OUT_SIGN;
    logic       OUT_SIGN_STB;
    logic       ERR;

    modport slave (
        input  IN_TOKEN, IN_IS_SIGN, IN_STB, IN_END,
        output IN_READY, OUT_NUMBER, OUT_NUMBER_STB, OUT_SIGN, OUT_SIGN_STB, ERR
    );

    modport master (
        output IN_TOKEN, IN_IS_SIGN, IN_STB, IN_END,
        input  IN_READY, OUT_NUMBER, OUT_NUMBER_STB, OUT_SIGN, OUT_SIGN_STB, ERR
    );
endinterface

// File: rtl/infix_sequencer.sv
// infix_sequencer: shunting-yard infix-to-postfix converter with paced operator output.
// Define INFIX_SEQ_STATS_EN to add OUT_TOKENS, a saturating count of emitted strobe cycles.
module infix_sequencer #(
    parameter int unsigned OP_DEPTH   = 16,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic CLK,
    input  logic RST,
    infix_sequencer_if.slave bus
`ifdef INFIX_SEQ_STATS_EN
    ,
    output logic [15:0] OUT_TOKENS
`endif
);
    localparam int unsigned PW = $clog2(OP_DEPTH);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam logic [PW:0] SP_ONE  = (PW+1)'(1);
    localparam logic [PW:0] SP_FULL = (PW+1)'(OP_DEPTH);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_ACCEPT, S_POP_PREC, S_POP_PAREN, S_DRAIN, S_TERM, S_GAP, S_ERROR
    } state_t;

    state_t        state, state_n, ret, ret_n;
    logic [7:0]    stack [OP_DEPTH];
    logic [PW:0]   sp;
    logic [PW-1:0] top_idx;
    logic [7:0]    top;
    logic          empty, full;
    logic [7:0]    held, held_n;
    logic [GW-1:0] gcnt, gcnt_n;
    logic          push, pop;
    logic [7:0]    push_val;
    logic          num_load, num_stb_q;
    logic [7:0]    num_q;
    logic          sign_stb, term;
    logic [7:0]    sign_val;
    logic          num_stb_o, sign_stb_o;

    function automatic logic [1:0] prec(input logic [7:0] op);
        case (op)
            "*", "/": return 2'd2;
            "+", "-": return 2'd1;
            default:  return 2'd0;
        endcase
    endfunction

    assign top_idx = PW'(sp - SP_ONE);
    assign top     = stack[top_idx];
    assign empty   = (sp == '0);
    assign full    = (sp == SP_FULL);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_ACCEPT;
            ret       <= S_ACCEPT;
            sp        <= '0;
            held      <= '0;
            gcnt      <= '0;
            num_stb_q <= 1'b0;
            num_q     <= '0;
        end else begin
            state     <= state_n;
            ret       <= ret_n;
            held      <= held_n;
            gcnt      <= gcnt_n;
            num_stb_q <= num_load;
            if (num_load) num_q <= bus.IN_TOKEN;
            if (push)     sp <= sp + SP_ONE;
            else if (pop) sp <= sp - SP_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !RST) stack[sp[PW-1:0]] <= push_val;
    end

    // Operator emits are combinational from the popping state so a token accepted
    // at cycle N produces its first sign strobe at N+1, matching the number path.
    always_comb begin
        state_n  = state;
        ret_n    = ret;
        held_n   = held;
        gcnt_n   = gcnt;
        push     = 1'b0;
        pop      = 1'b0;
        push_val = held;
        num_load = 1'b0;
        sign_stb = 1'b0;
        sign_val = '0;
        term     = 1'b0;
        case (state)
            S_ACCEPT: begin
                if (bus.IN_STB) begin
                    if (bus.IN_END) begin
                        state_n = empty ? S_TERM : S_DRAIN;
                    end else if (!bus.IN_IS_SIGN) begin
                        num_load = 1'b1;
                    end else begin
                        case (bus.IN_TOKEN)
                            "(": begin
                                if (full) state_n = S_ERROR;
                                else begin
                                    push     = 1'b1;
                                    push_val = "(";
                                end
                            end
                            ")": state_n = empty ? S_ERROR : S_POP_PAREN;
                            "+", "-", "*", "/": begin
                                held_n  = bus.IN_TOKEN;
                                state_n = S_POP_PREC;
                            end
                            default: state_n = S_ERROR;
                        endcase
                    end
                end
            end
            S_POP_PREC: begin
                if (!empty && prec(top) >= prec(held)) begin
                    pop      = 1'b1;
                    sign_stb = 1'b1;
                    sign_val = top;
                    state_n  = S_GAP;
                    ret_n    = S_POP_PREC;
                    gcnt_n   = GAP_LOAD;
                end else if (full) begin
                    state_n = S_ERROR;
                end else begin
                    push    = 1'b1;
                    state_n = S_ACCEPT;
                end
            end
            S_POP_PAREN: begin
                if (empty) begin
                    state_n = S_ERROR;
                end else if (top == "(") begin
                    pop     = 1'b1;
                    state_n = S_ACCEPT;
                end else begin
                    pop      = 1'b1;
                    sign_stb = 1'b1;
                    sign_val = top;
                    state_n  = S_GAP;
                    ret_n    = S_POP_PAREN;
                    gcnt_n   = GAP_LOAD;
                end
            end
            S_DRAIN: begin
                if (empty) begin
                    state_n = S_TERM;
                end else if (top == "(") begin
                    state_n = S_ERROR;
                end else begin
                    pop      = 1'b1;
                    sign_stb = 1'b1;
                    sign_val = top;
                    state_n  = S_GAP;
                    ret_n    = S_DRAIN;
                    gcnt_n   = GAP_LOAD;
                end
            end
            S_TERM: begin
                term     = 1'b1;
                sign_stb = 1'b1;
                sign_val = 8'h3D;
                state_n  = S_GAP;
                ret_n    = S_ACCEPT;
                gcnt_n   = GAP_LOAD;
            end
            S_GAP: begin
                if (gcnt == '0) state_n = ret;
                else            gcnt_n  = gcnt - GW'(1);
            end
            S_ERROR: state_n = S_ERROR;
            default: state_n = S_ERROR;
        endcase
    end

    // Strobes are masked while RST is high so an in-flight drain emits nothing.
    assign num_stb_o  = (num_stb_q | term) & ~RST;
    assign sign_stb_o = sign_stb & ~RST;

    assign bus.IN_READY       = (state == S_ACCEPT) || (state == S_ERROR);
    assign bus.ERR            = (state == S_ERROR);
    assign bus.OUT_NUMBER_STB = num_stb_o;
    assign bus.OUT_NUMBER     = (num_stb_o && !term) ? num_q : '0;
    assign bus.OUT_SIGN_STB   = sign_stb_o;
    assign bus.OUT_SIGN       = sign_stb_o ? sign_val : '0;

`ifdef INFIX_SEQ_STATS_EN
    logic [15:0] tok_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            tok_cnt <= '0;
        end else if ((num_stb_o || sign_stb_o) && state != S_ERROR && tok_cnt != 16'hFFFF) begin
            tok_cnt <= tok_cnt + 16'd1;
        end
    end

    assign OUT_TOKENS = tok_cnt;
`endif
endmodule

// File: tb/tb_infix_sequencer.sv
// tb_infix_sequencer: randomized and directed checks of infix_sequencer against a queue-based
// shunting-yard reference model; also checks sign pacing and reset/error behaviour.
module tb_infix_sequencer;
    localparam int OP_DEPTH   = 16;
    localparam int GAP_CYCLES = 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    infix_sequencer_if bus();
`ifdef INFIX_SEQ_STATS_EN
    logic [15:0] OUT_TOKENS;
`endif

    infix_sequencer #(.OP_DEPTH(OP_DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
`ifdef INFIX_SEQ_STATS_EN
        ,
        .OUT_TOKENS(OUT_TOKENS)
`endif
    );

    int checks = 0;
    int fails  = 0;

    // stim entries: {end, is_sign, value}; events: {kind ASCII N/S/T, value}
    logic [9:0]  stim[$];
    logic [15:0] expq[$];
    logic [15:0] got[$];
    bit          exp_err;

    int gap_left      = 0;
    int gap_viol      = 0;
    int proto_err     = 0;
    int strobe_cycles = 0;

    always @(negedge CLK) begin
        if (RST) begin
            gap_left      = 0;
            strobe_cycles = 0;
        end
        if (bus.OUT_NUMBER_STB === 1'b1 || bus.OUT_SIGN_STB === 1'b1) begin
            if (RST) proto_err++;
            if (gap_left > 0) gap_viol++;
            strobe_cycles++;
            if (bus.OUT_NUMBER_STB === 1'b1 && bus.OUT_SIGN_STB === 1'b1) begin
                if (bus.OUT_SIGN === 8'h3D && bus.OUT_NUMBER === 8'h00) got.push_back({"T", 8'h3D});
                else proto_err++;
                gap_left = GAP_CYCLES;
            end else if (bus.OUT_NUMBER_STB === 1'b1) begin
                got.push_back({"N", bus.OUT_NUMBER});
            end else begin
                got.push_back({"S", bus.OUT_SIGN});
                gap_left = GAP_CYCLES;
            end
        end else if (gap_left > 0) begin
            gap_left--;
        end
    end

    function automatic logic [9:0] tnum(input logic [7:0] v);
        return {2'b00, v};
    endfunction
    function automatic logic [9:0] top_(input logic [7:0] c);
        return {2'b01, c};
    endfunction
    function automatic logic [9:0] tend();
        return {2'b10, 8'h00};
    endfunction
    function automatic logic [15:0] ev(input logic [7:0] k, input logic [7:0] v);
        return {k, v};
    endfunction

    function automatic int prec_of(input logic [7:0] c);
        if (c == "*" || c == "/") return 2;
        if (c == "+" || c == "-") return 1;
        return 0;
    endfunction

    // Reference: textbook shunting-yard over a queue, one expression per END.
    task automatic build_expected();
        logic [7:0] ops[$];
        logic [9:0] t;
        logic [7:0] c;
        expq.delete();
        exp_err = 1'b0;
        foreach (stim[i]) begin
            if (exp_err) break;
            t = stim[i];
            if (t[9]) begin
                while (ops.size() > 0 && !exp_err) begin
                    if (ops[$] == "(") exp_err = 1'b1;
                    else begin
                        c = ops.pop_back();
                        expq.push_back(ev("S", c));
                    end
                end
                if (!exp_err) expq.push_back(ev("T", 8'h3D));
                ops.delete();
            end else if (!t[8]) begin
                expq.push_back(ev("N", t[7:0]));
            end else if (t[7:0] == "(") begin
                if (ops.size() >= OP_DEPTH) exp_err = 1'b1;
                else ops.push_back("(");
            end else if (t[7:0] == ")") begin
                while (ops.size() > 0 && ops[$] != "(") begin
                    c = ops.pop_back();
                    expq.push_back(ev("S", c));
                end
                if (ops.size() == 0) exp_err = 1'b1;
                else c = ops.pop_back();
            end else if (prec_of(t[7:0]) > 0) begin
                while (ops.size() > 0 && prec_of(ops[$]) >= prec_of(t[7:0])) begin
                    c = ops.pop_back();
                    expq.push_back(ev("S", c));
                end
                if (ops.size() >= OP_DEPTH) exp_err = 1'b1;
                else ops.push_back(t[7:0]);
            end else begin
                exp_err = 1'b1;
            end
        end
    endtask

    function automatic logic [7:0] pick_op();
        case ($urandom_range(0, 3))
            0:       return "+";
            1:       return "-";
            2:       return "*";
            default: return "/";
        endcase
    endfunction

    task automatic gen_expr(input int max_ops);
        int depth = 0;
        int nops  = $urandom_range(0, max_ops);
        for (int k = 0; k <= nops; k++) begin
            while (depth < 3 && $urandom_range(0, 3) == 0) begin
                stim.push_back(top_("("));
                depth++;
            end
            stim.push_back(tnum(8'($urandom_range(0, 255))));
            while (depth > 0 && $urandom_range(0, 2) == 0) begin
                stim.push_back(top_(")"));
                depth--;
            end
            if (k < nops) stim.push_back(top_(pick_op()));
        end
        while (depth > 0) begin
            stim.push_back(top_(")"));
            depth--;
        end
        stim.push_back(tend());
    endtask

    function automatic int seq_diff();
        int n = (got.size() > expq.size()) ? got.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            if (i >= got.size() || i >= expq.size()) return i;
            if (got[i] !== expq[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] got_at(input int i);
        return (i >= 0 && i < got.size()) ? got[i] : 16'hFFFF;
    endfunction
    function automatic logic [15:0] exp_at(input int i);
        return (i >= 0 && i < expq.size()) ? expq[i] : 16'hFFFF;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic drive(input logic [9:0] t);
        int n = 0;
        @(negedge CLK);
        #1;
        while (bus.IN_READY !== 1'b1 && n < 200) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            fails++;
            $display("FAIL drive_ready: IN_READY=%b after %0d cycles, required 1", bus.IN_READY, n);
        end
        bus.IN_STB     = 1'b1;
        bus.IN_END     = t[9];
        bus.IN_IS_SIGN = t[8];
        bus.IN_TOKEN   = t[7:0];
        @(posedge CLK);
        #1;
        bus.IN_STB     = 1'b0;
        bus.IN_END     = 1'b0;
        bus.IN_IS_SIGN = 1'b0;
        bus.IN_TOKEN   = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        got.delete();
    endtask

    task automatic run_stim();
        int n = 0;
        got.delete();
        foreach (stim[i]) drive(stim[i]);
        while (n < 400 && (exp_err ? (bus.ERR !== 1'b1) : (got.size() < expq.size()))) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (n >= 400) begin
            checks++;
            fails++;
            $display("FAIL completion_timeout: %0d events seen, required %0d, ERR=%b", got.size(), expq.size(), bus.ERR);
        end
        idle(GAP_CYCLES + 6);
    endtask

    task automatic test_reset();
        bus.IN_STB = 1'b0; bus.IN_END = 1'b0; bus.IN_IS_SIGN = 1'b0; bus.IN_TOKEN = 8'h00;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            fails++; $display("FAIL reset_ready: IN_READY=%b required 1", bus.IN_READY);
        end
        checks++;
        if (bus.ERR !== 1'b0) begin
            fails++; $display("FAIL reset_err: ERR=%b required 0", bus.ERR);
        end
        checks++;
        if ({bus.OUT_NUMBER_STB, bus.OUT_SIGN_STB, bus.OUT_NUMBER, bus.OUT_SIGN} !== 18'h0) begin
            fails++;
            $display("FAIL reset_outputs: nstb=%b sstb=%b num=%h sign=%h required all 0",
                     bus.OUT_NUMBER_STB, bus.OUT_SIGN_STB, bus.OUT_NUMBER, bus.OUT_SIGN);
        end
        got.delete();
    endtask

    task automatic test_spec_vectors();
        int d;
        // 3 + 4 * 2
        stim = '{tnum(3), top_("+"), tnum(4), top_("*"), tnum(2), tend()};
        expq = '{ev("N", 3), ev("N", 4), ev("N", 2), ev("S", "*"), ev("S", "+"), ev("T", 8'h3D)};
        exp_err = 1'b0;
        run_stim();
        checks++; d = seq_diff();
        if (d >= 0) begin
            fails++; $display("FAIL precedence: event %0d got %h required %h", d, got_at(d), exp_at(d));
        end
        // ( 1 + 2 ) * 3
        stim = '{top_("("), tnum(1), top_("+"), tnum(2), top_(")"), top_("*"), tnum(3), tend()};
        expq = '{ev("N", 1), ev("N", 2), ev("S", "+"), ev("N", 3), ev("S", "*"), ev("T", 8'h3D)};
        run_stim();
        checks++; d = seq_diff();
        if (d >= 0) begin
            fails++; $display("FAIL parens: event %0d got %h required %h", d, got_at(d), exp_at(d));
        end
        // 8 - 2 - 1
        stim = '{tnum(8), top_("-"), tnum(2), top_("-"), tnum(1), tend()};
        expq = '{ev("N", 8), ev("N", 2), ev("S", "-"), ev("N", 1), ev("S", "-"), ev("T", 8'h3D)};
        run_stim();
        checks++; d = seq_diff();
        if (d >= 0) begin
            fails++; $display("FAIL left_assoc: event %0d got %h required %h", d, got_at(d), exp_at(d));
        end
        checks++;
        if (bus.ERR !== 1'b0) begin
            fails++; $display("FAIL spec_vectors_err: ERR=%b required 0", bus.ERR);
        end
    endtask

    task automatic test_empty_and_end_priority();
        int d;
        stim = '{tend()};
        expq = '{ev("T", 8'h3D)};
        exp_err = 1'b0;
        run_stim();
        checks++; d = seq_diff();
        if (d >= 0) begin
            fails++; $display("FAIL empty_expr: event %0d got %h required %h", d, got_at(d), exp_at(d));
        end
        // IN_END together with a '(' sign: the token must be ignored
        stim = '{tnum(3), top_("+"), tnum(4), {2'b11, 8'h28}};
        expq = '{ev("N", 3), ev("N", 4), ev("S", "+"), ev("T", 8'h3D)};
        run_stim();
        checks++; d = seq_diff();
        if (d >= 0) begin
            fails++; $display("FAIL end_wins: event %0d got %h required %h", d, got_at(d), exp_at(d));
        end
    endtask

    task automatic test_random_exprs();
        int d;
        for (int k = 0; k < 25; k++) begin
            stim.delete();
            gen_expr(5);
            build_expected();
            run_stim();
            checks++; d = seq_diff();
            if (d >= 0) begin
                fails++;
                $display("FAIL random_expr %0d: event %0d got %h required %h (%0d vs %0d events)",
                         k, d, got_at(d), exp_at(d), got.size(), expq.size());
            end
            checks++;
            if (bus.ERR !== exp_err) begin
                fails++; $display("FAIL random_expr_err %0d: ERR=%b required %b", k, bus.ERR, exp_err);
            end
        end
    endtask

    task automatic test_random_malformed();
        int d;
        int len;
        logic [7:0] signs [7];
        signs = '{"+", "-", "*", "/", "(", ")", "x"};
        for (int k = 0; k < 20; k++) begin
            do_reset();
            stim.delete();
            len = $urandom_range(1, 10);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 1) == 0) stim.push_back(tnum(8'($urandom_range(0, 255))));
                else stim.push_back(top_(signs[$urandom_range(0, ($urandom_range(0, 7) == 0) ? 6 : 5)]));
            end
            stim.push_back(tend());
            build_expected();
            run_stim();
            checks++; d = seq_diff();
            if (d >= 0) begin
                fails++;
                $display("FAIL malformed %0d: event %0d got %h required %h (%0d vs %0d events)",
                         k, d, got_at(d), exp_at(d), got.size(), expq.size());
            end
            checks++;
            if (bus.ERR !== exp_err) begin
                fails++; $display("FAIL malformed_err %0d: ERR=%b required %b", k, bus.ERR, exp_err);
            end
        end
        do_reset();
    endtask

    task automatic test_errors();
        int d;
        do_reset();
        drive(top_(")"));
        checks++;
        if (bus.ERR !== 1'b1) begin
            fails++; $display("FAIL unmatched_close_err: ERR=%b required 1", bus.ERR);
        end
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            fails++; $display("FAIL error_ready: IN_READY=%b required 1", bus.IN_READY);
        end
        drive(tnum(7)); drive(top_("+")); drive(tnum(1)); drive(tend());
        idle(6);
        checks++;
        if (got.size() != 0) begin
            fails++; $display("FAIL error_silent: %0d strobes seen, required 0", got.size());
        end
        do_reset();
        checks++;
        if (bus.ERR !== 1'b0 || bus.IN_READY !== 1'b1) begin
            fails++; $display("FAIL error_cleared: ERR=%b IN_READY=%b required 0/1", bus.ERR, bus.IN_READY);
        end
        for (int i = 0; i < OP_DEPTH; i++) drive(top_("("));
        checks++;
        if (bus.ERR !== 1'b0) begin
            fails++; $display("FAIL stack_full_ok: ERR=%b required 0", bus.ERR);
        end
        drive(top_("("));
        checks++;
        if (bus.ERR !== 1'b1) begin
            fails++; $display("FAIL overflow: ERR=%b required 1", bus.ERR);
        end
        do_reset();
        stim = '{top_("("), tnum(5), tend()};
        expq = '{ev("N", 5)};
        exp_err = 1'b1;
        run_stim();
        checks++; d = seq_diff();
        if (d >= 0) begin
            fails++; $display("FAIL unmatched_open: event %0d got %h required %h", d, got_at(d), exp_at(d));
        end
        checks++;
        if (bus.ERR !== 1'b1) begin
            fails++; $display("FAIL unmatched_open_err: ERR=%b required 1", bus.ERR);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_drain();
        int d;
        int n = 0;
        got.delete();
        stim = '{tnum(1), top_("+"), tnum(2), top_("*"), tnum(3), tend()};
        foreach (stim[i]) drive(stim[i]);
        while (got.size() < 4 && n < 100) begin
            @(negedge CLK);
            #1;
            n++;
        end
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle(8);
        expq = '{ev("N", 1), ev("N", 2), ev("N", 3), ev("S", "*")};
        checks++; d = seq_diff();
        if (d >= 0) begin
            fails++; $display("FAIL reset_mid_drain: event %0d got %h required %h (%0d events)",
                              d, got_at(d), exp_at(d), got.size());
        end
        stim = '{tnum(2), top_("*"), tnum(3), top_("+"), tnum(4), tend()};
        expq = '{ev("N", 2), ev("N", 3), ev("S", "*"), ev("N", 4), ev("S", "+"), ev("T", 8'h3D)};
        exp_err = 1'b0;
        run_stim();
        checks++; d = seq_diff();
        if (d >= 0) begin
            fails++; $display("FAIL after_mid_reset: event %0d got %h required %h", d, got_at(d), exp_at(d));
        end
    endtask

    task automatic test_back_to_back();
        int d;
        for (int k = 0; k < 4; k++) begin
            stim.delete();
            gen_expr(4);
            gen_expr(4);
            gen_expr(2);
            build_expected();
            run_stim();
            checks++; d = seq_diff();
            if (d >= 0) begin
                fails++;
                $display("FAIL back_to_back %0d: event %0d got %h required %h (%0d vs %0d events)",
                         k, d, got_at(d), exp_at(d), got.size(), expq.size());
            end
        end
    endtask

`ifdef INFIX_SEQ_STATS_EN
    task automatic test_stats();
        logic [15:0] frozen;
        do_reset();
        checks++;
        if (OUT_TOKENS !== 16'd0) begin
            fails++; $display("FAIL stats_reset: OUT_TOKENS=%0d required 0", OUT_TOKENS);
        end
        stim = '{tnum(3), top_("+"), tnum(4), top_("*"), tnum(2), tend()};
        expq = '{ev("N", 3), ev("N", 4), ev("N", 2), ev("S", "*"), ev("S", "+"), ev("T", 8'h3D)};
        exp_err = 1'b0;
        run_stim();
        checks++;
        if (OUT_TOKENS !== 16'd6) begin
            fails++; $display("FAIL stats_count: OUT_TOKENS=%0d required 6", OUT_TOKENS);
        end
        frozen = OUT_TOKENS;
        drive(top_("x"));
        drive(tnum(9)); drive(tend());
        idle(4);
        checks++;
        if (OUT_TOKENS !== frozen) begin
            fails++; $display("FAIL stats_frozen: OUT_TOKENS=%0d required %0d", OUT_TOKENS, frozen);
        end
        do_reset();
    endtask
`endif

    task automatic test_pacing();
        checks++;
        if (gap_viol != 0) begin
            fails++; $display("FAIL sign_gap: %0d strobes inside a gap, required 0", gap_viol);
        end
        checks++;
        if (proto_err != 0) begin
            fails++; $display("FAIL strobe_protocol: %0d bad strobe cycles, required 0", proto_err);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_spec_vectors();
        test_empty_and_end_priority();
        test_random_exprs();
        test_back_to_back();
        test_errors();
        test_random_malformed();
        test_reset_mid_drain();
`ifdef INFIX_SEQ_STATS_EN
        test_stats();
`endif
        test_pacing();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
